// File: rtl/alu3_seq.sv
// rtl/alu3_seq.sv - sequential 3-bit ALU feeding the seven-segment result stage
// Optional iterative multiply is enabled with `define ALU_MUL_EN; otherwise Op=111 reports Ovf=1.
module alu3_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] A,
   input  logic [2:0] B,
   input  logic [2:0] Op,
   output logic       busy,
   output logic       done,
   output logic [3:0] Result,
   output logic       Ovf
);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_EXEC} state_t;
`endif

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_a;
   logic [2:0] r_b;
   logic [2:0] r_op;
   logic [3:0] r_result;
   logic       r_ovf;
   logic       r_busy;
   logic       r_done;

   logic       w_latch;
   logic       w_complete;
   logic [3:0] w_cpl_result;
   logic       w_cpl_ovf;
   logic [3:0] w_alu_result;
   logic       w_alu_ovf;
   logic [3:0] w_sub;

`ifdef ALU_MUL_EN
   logic [5:0] r_acc;
   logic [2:0] r_cnt;
   logic [5:0] w_acc_nxt;
   logic [2:0] w_cnt_nxt;
`endif

   assign w_sub = {1'b0, r_a} - {1'b0, r_b};

   // Single-cycle datapath; Op=111 only lands here when multiply is not built in.
   always_comb begin
      w_alu_result = 4'd0;
      w_alu_ovf    = 1'b0;
      case (r_op)
         3'b000: w_alu_result = {1'b0, r_a} + {1'b0, r_b};
         3'b001: begin
            w_alu_result = w_sub;
            w_alu_ovf    = (r_a < r_b);
         end
         3'b010: w_alu_result = {1'b0, r_a & r_b};
         3'b011: w_alu_result = {1'b0, r_a | r_b};
         3'b100: w_alu_result = {1'b0, r_a ^ r_b};
         3'b101: w_alu_result = {1'b0, ~r_a};
         3'b110: w_alu_result = {r_a, 1'b0};
         default: begin
            w_alu_result = 4'd0;
            w_alu_ovf    = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_latch      = 1'b0;
      w_complete   = 1'b0;
      w_cpl_result = w_alu_result;
      w_cpl_ovf    = w_alu_ovf;
`ifdef ALU_MUL_EN
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_latch     = 1'b1;
               w_state_nxt = S_EXEC;
`ifdef ALU_MUL_EN
               if (Op == 3'b111) begin
                  w_state_nxt = S_MUL;
                  w_acc_nxt   = 6'd0;
                  w_cnt_nxt   = B;
               end
`endif
            end
         end
         S_EXEC: begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            if (r_cnt != 3'd0) begin
               w_acc_nxt = r_acc + {3'b000, r_a};
               w_cnt_nxt = r_cnt - 3'd1;
            end else begin
               // Saturate to the 4-bit display range and flag the true overflow.
               w_complete   = 1'b1;
               w_cpl_result = (r_acc > 6'd15) ? 4'hF : r_acc[3:0];
               w_cpl_ovf    = (r_acc > 6'd15);
               w_state_nxt  = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= 3'd0;
         r_b      <= 3'd0;
         r_op     <= 3'd0;
         r_result <= 4'd0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= Op;
         end
         if (w_complete) begin
            r_result <= w_cpl_result;
            r_ovf    <= w_cpl_ovf;
         end
         r_done <= w_complete;
         r_busy <= (w_state_nxt != S_IDLE);
      end
   end

`ifdef ALU_MUL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= 6'd0;
         r_cnt <= 3'd0;
      end else begin
         r_acc <= w_acc_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end
`endif

   assign busy   = r_busy;
   assign done   = r_done;
   assign Result = r_result;
   assign Ovf    = r_ovf;

endmodule

// File: tb/tb_alu3_seq.sv
// tb/tb_alu3_seq.sv - scoreboard bench for alu3_seq
module tb_alu3_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] A;
   logic [2:0] B;
   logic [2:0] Op;
   logic       busy;
   logic       done;
   logic [3:0] Result;
   logic       Ovf;

   typedef struct {
      logic [3:0] res;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   alu3_seq dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Op(Op),
      .busy(busy), .done(done), .Result(Result), .Ovf(Ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: Result=%0d Ovf=%0d at cycle %0d", Result, Ovf, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", 32'(Result), 32'(e.res));
            chk("ovf", 32'(Ovf), 32'(e.ovf));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic push(input logic [3:0] r, input logic o, input int lat);
      exp_t e;
      e.res = r;
      e.ovf = o;
      e.cyc = cyc + 1 + lat;
      q.push_back(e);
   endtask

   task automatic wait_done(output int busy_cycles);
      bit seen = 0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic eo, input int lat);
      int bc;
      A = a;
      B = b;
      Op = op;
      start = 1'b1;
      push(er, eo, lat);
      @(negedge clk);
      start = 1'b0;
      wait_done(bc);
      chk("busy_cycles", 32'(bc), 32'(lat));
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(Result), 32'd0);
      chk("rst_ovf", 32'(Ovf), 32'd0);
   endtask

   initial begin
      int bc;
      rst = 1'b1;
      start = 1'b1;
      A = 3'd7;
      B = 3'd7;
      Op = 3'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 32'(busy), 32'd0);

      issue(3'd7, 3'd7, 3'b000, 4'd14, 1'b0, 1);
      issue(3'd2, 3'd5, 3'b001, 4'b1101, 1'b1, 1);
      issue(3'd5, 3'd3, 3'b010, 4'd1, 1'b0, 1);
      issue(3'd5, 3'd3, 3'b011, 4'd7, 1'b0, 1);
      issue(3'd5, 3'd3, 3'b100, 4'd6, 1'b0, 1);
      issue(3'd5, 3'd3, 3'b101, 4'd2, 1'b0, 1);
      issue(3'd5, 3'd3, 3'b110, 4'd10, 1'b0, 1);
`ifdef ALU_MUL_EN
      issue(3'd3, 3'd4, 3'b111, 4'd12, 1'b0, 5);
      issue(3'd7, 3'd7, 3'b111, 4'd15, 1'b1, 8);
      issue(3'd6, 3'd0, 3'b111, 4'd0, 1'b0, 1);
`else
      issue(3'd3, 3'd4, 3'b111, 4'd0, 1'b1, 1);
`endif
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

`ifdef ALU_MUL_EN
      A = 3'd7; B = 3'd7; Op = 3'b111; start = 1'b1;
      push(4'd15, 1'b1, 8);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 3'd1; B = 3'd1; Op = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(bc);
      @(negedge clk);
      A = 3'd7; B = 3'd7; Op = 3'b111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
`else
      A = 3'd7; B = 3'd7; Op = 3'b000; start = 1'b1;
      push(4'd14, 1'b0, 1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(bc);
      @(negedge clk);
      A = 3'd1; B = 3'd1; Op = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
`endif
      check_reset_outputs();
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu3_seq.md
# alu3_seq

Sequential 3-bit ALU that produces the 4-bit `Result` consumed by the two-digit seven-segment decoder stage. It latches operands and an opcode on a `start` request. Single-cycle operations finish on the next clock; multiply is computed iteratively by repeated addition. `Result` is held stable between completions so the display stage always sees a settled value.

## Interface
- No parameters; widths are fixed.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  3  operand A, unsigned.
- B  input  3  operand B, unsigned; also the multiply iteration count.
- Op  input  3  opcode.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when `Result`/`Ovf` update.
- Result  output  4  registered result; held until the next `done`.
- Ovf  output  1  overflow or borrow flag, registered with `Result`.

## Operation
- States:
  - IDLE: `start=1` latches A, B and Op; next state is EXEC, or MUL when Op=111.
  - EXEC: computes the result, writes `Result`/`Ovf`, pulses `done`, then returns to IDLE.
  - MUL: iterates; see below.
- Opcodes (all results 4 bits; 3-bit values are zero-extended):
  - 000 ADD: A+B (range 0..14); Ovf=0.
  - 001 SUB: (A−B) mod 16; Ovf=1 iff A<B (borrow). Example: 2−5 gives 4'b1101 with Ovf=1.
  - 010 AND, 011 OR, 100 XOR: bitwise; Ovf=0.
  - 101 NOT: {1'b0, ~A}; Ovf=0.
  - 110 SHL: {A,1'b0}; Ovf=0.
  - 111 MUL: A×B, saturated to 15; Ovf=1 iff the true product is >15.
- MUL:
  - On entry: 6-bit accumulator acc=0, 3-bit counter cnt=B.
  - Each edge with cnt≠0: acc+=A, cnt−=1.
  - Edge with cnt==0: Result=min(acc,15), Ovf=(acc>15), `done` pulses, return to IDLE.
- `start` while busy is ignored; no queuing. The latched operands are not affected by input changes during an operation.
- `done` and `start` high in the same cycle: the new request is accepted, because the FSM is back in IDLE that cycle.

## Timing
- Reset values: busy=0, done=0, Result=4'b0000, Ovf=0, state IDLE, acc=0, cnt=0.
- Reset mid-operation aborts it: all outputs return to their reset values on that edge and no `done` is issued.
- rst and start on the same edge: reset wins and the request is dropped.
- Let edge k be the edge that samples `start`:
  - busy=1 from edge k until the completion edge.
  - Non-MUL: completion edge is k+1.
  - MUL: completion edge is k+1+B (B=0 completes at k+1 with Result=0).
- On the completion edge: Result/Ovf update, done=1 for exactly one cycle, busy=0.
- Back-to-back operations: the earliest next accept is the edge after completion.
- `Result` changes only on a completion edge or on reset.

## Configuration
- `ALU_MUL_EN` defined: Op=111 performs iterative MUL as specified, using the MUL state, acc and cnt.
- `ALU_MUL_EN` undefined: the MUL state, acc and cnt are removed. Op=111 goes through EXEC and completes at edge k+1 with Result=0 and Ovf=1 (unsupported-op indication).

## Test plan
- Reset: hold rst for 2 cycles → busy=0, done=0, Result=0, Ovf=0; `start` during reset is ignored.
- ADD/SUB: A=7, B=7, Op=000 → Result=14, Ovf=0, done at k+1. Then A=2, B=5, Op=001 → Result=4'b1101, Ovf=1.
- Logic sweep: A=5, B=3 with Op=010/011/100/101/110 → Result=1, 7, 6, 2, 10 respectively; Ovf=0 each; `done` one cycle each.
- MUL (ALU_MUL_EN):
  - A=3, B=4 → busy for 5 cycles, done at k+5, Result=12, Ovf=0.
  - A=7, B=7 → done at k+8, Result=15, Ovf=1.
  - A=6, B=0 → done at k+1, Result=0.
- Busy/abort:
  - Start A=7, B=7 MUL; pulse `start` with Op=000 at k+2 → ignored; Result=15.
  - Repeat and assert rst at k+3 → no `done`; outputs return to reset values.
- ALU_MUL_EN undefined: A=3, B=4, Op=111 → done at k+1, Result=0, Ovf=1.
